pmem_line_model: RTL and testbench

Parametrised, cycle-accurate physical memory responder for full-line cache traffic. It is the successor to the fixed-latency line memory used by the CPU benches. Line width, depth, and separate read/write latencies are configurable, and protocol violations are detected and recorded in a sticky cause register. It sits behind the cache's pmem_* port, in a testbench or as a synthesizable stand-in on the FPGA build.

---
 rtl/pmem_model_pkg.sv | 22 ++
 rtl/pmem_line_array.sv | 24 ++
 rtl/pmem_line_model.sv | 135 +++++++++++++
 tb/tb_pmem_line_model.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_model_pkg.sv
// Shared types and helpers for the parametrised full-line physical memory responder.
package pmem_model_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Members are listed MSB first so that rw_both lands on bit 0 of err_cause.
  typedef struct packed {
    logic dropped;
    logic out_of_range;
    logic misaligned;
    logic rw_both;
  } err_cause_t;

  function automatic int line_offset_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: one synchronous write port and one combinational read port.
module pmem_line_array #(
  parameter  int LINE_BITS   = 256,
  parameter  int DEPTH_LINES = 1024,
  localparam int IDX_BITS    = $clog2(DEPTH_LINES)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_BITS-1:0]  waddr,
  input  logic [LINE_BITS-1:0] wdata,
  input  logic [IDX_BITS-1:0]  raddr,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] mem [DEPTH_LINES];

  // NOTE: the storage array has no reset; clearing it would turn it into flops and break RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pmem_line_model.sv
// Cycle-accurate line memory responder with configurable latencies and sticky protocol-violation capture.
module pmem_line_model
  import pmem_model_pkg::*;
#(
  parameter int LINE_BITS     = 256,
  parameter int DEPTH_LINES   = 1024,
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          address,
  input  logic [LINE_BITS-1:0] wdata,
  output logic                 resp,
  output logic [LINE_BITS-1:0] rdata,
  output logic                 error,
  output logic [3:0]           err_cause
);

  localparam int OFFSET   = line_offset_bits(LINE_BITS);
  localparam int IDX_BITS = $clog2(DEPTH_LINES);
  localparam int CNT_BITS = $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);
  localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFFSET) - 64'd1);

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  op_write_q;
  logic [31:0]           addr_q;
  logic [LINE_BITS-1:0]  wdata_q;
  logic                  resp_q;
  logic [LINE_BITS-1:0]  rdata_q;
  err_cause_t            cause_q;

  logic                  accept, rw_both, mismatch, complete;
  logic [CNT_BITS-1:0]   lat_first;
  logic                  cmp_write, cmp_in_range;
  logic [31:0]           cmp_addr, cmp_line;
  logic [LINE_BITS-1:0]  cmp_wdata, arr_rdata;
  logic [IDX_BITS-1:0]   cmp_index;
  logic                  arr_we;

  assign accept    = (state_q == IDLE) && (read ^ write);
  assign rw_both   = (state_q == IDLE) && read && write;
  assign lat_first = write ? CNT_BITS'(WRITE_LATENCY - 1) : CNT_BITS'(READ_LATENCY - 1);

  // Wdata only matters to a write; a read's wdata bus may wander freely.
  assign mismatch = (state_q == BUSY) &&
                    ((read != !op_write_q) || (write != op_write_q) || (address != addr_q) ||
                     (op_write_q && (wdata != wdata_q)));

  // A latency-1 request completes on its acceptance edge, so it is served from the live bus.
  assign complete  = (accept && (lat_first == '0)) ||
                     ((state_q == BUSY) && !mismatch && (cnt_q == CNT_BITS'(1)));
  assign cmp_write = (state_q == IDLE) ? write   : op_write_q;
  assign cmp_addr  = (state_q == IDLE) ? address : addr_q;
  assign cmp_wdata = (state_q == IDLE) ? wdata   : wdata_q;

  assign cmp_line     = cmp_addr >> OFFSET;
  assign cmp_in_range = cmp_line < 32'(DEPTH_LINES);
  assign cmp_index    = cmp_addr[OFFSET +: IDX_BITS];
  assign arr_we       = complete && cmp_write && cmp_in_range;

  pmem_line_array #(
    .LINE_BITS   (LINE_BITS),
    .DEPTH_LINES (DEPTH_LINES)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (cmp_index),
    .wdata (cmp_wdata),
    .raddr (cmp_index),
    .rdata (arr_rdata)
  );

  // NOTE: every signal driven here gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = lat_first;
          state_d = (lat_first == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (mismatch) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      cause_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= complete;
      if (accept) begin
        op_write_q <= write;
        addr_q     <= address;
        wdata_q    <= wdata;
      end
      if (complete && !cmp_write) rdata_q <= cmp_in_range ? arr_rdata : '0;
      cause_q.rw_both      <= cause_q.rw_both      | rw_both;
      cause_q.misaligned   <= cause_q.misaligned   | (accept && ((address & OFF_MASK) != '0));
      cause_q.out_of_range <= cause_q.out_of_range | (accept && ((address >> OFFSET) >= 32'(DEPTH_LINES)));
      cause_q.dropped      <= cause_q.dropped      | mismatch;
    end
  end

  assign resp      = resp_q;
  assign rdata     = rdata_q;
  assign err_cause = cause_q;
  assign error     = |cause_q;

endmodule

// File: tb/tb_pmem_line_model.sv
// Directed bench: a default-latency instance and a fast (read 1 / write 3, 16-line) instance.
module tb_pmem_line_model;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         r0 = 0, w0 = 0, r1 = 0, w1 = 0;
  logic [31:0]  a0 = 0, a1 = 0;
  logic [255:0] d0 = 0, d1 = 0;
  logic         resp0, resp1, err0, err1;
  logic [255:0] rd0, rd1;
  logic [3:0]   ec0, ec1;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] A5   = {32{8'hA5}};
  localparam logic [255:0] PAT  = {4{64'h1234_5678_9ABC_DEF0}};
  localparam logic [255:0] PAT2 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PATZ = {8{32'h0F0F_F0F0}};

  pmem_line_model dut0 (
    .clk(clk), .rst(rst), .read(r0), .write(w0), .address(a0), .wdata(d0),
    .resp(resp0), .rdata(rd0), .error(err0), .err_cause(ec0)
  );

  pmem_line_model #(
    .LINE_BITS(256), .DEPTH_LINES(16), .READ_LATENCY(1), .WRITE_LATENCY(3)
  ) dut1 (
    .clk(clk), .rst(rst), .read(r1), .write(w1), .address(a1), .wdata(d1),
    .resp(resp1), .rdata(rd1), .error(err1), .err_cause(ec1)
  );

  // Drives a request immediately, counts rising edges until resp, then drops the request.
  task automatic transact(input int sel, input bit wr, input logic [31:0] addr,
                          input logic [255:0] data, output int lat, output logic [255:0] rd);
    lat = -1;
    if (sel == 0) begin r0 = !wr; w0 = wr; a0 = addr; d0 = data; end
    else          begin r1 = !wr; w1 = wr; a1 = addr; d1 = data; end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (((sel == 0) ? resp0 : resp1) === 1'b1) begin lat = n; break; end
    end
    rd = (sel == 0) ? rd0 : rd1;
    if (sel == 0) begin r0 = 0; w0 = 0; end
    else          begin r1 = 0; w1 = 0; end
  endtask

  task automatic gap();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic chk_lat(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s latency got=%0d expected=%0d", name, got, exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    total++; if (resp0 !== 1'b0 || resp1 !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b%b expected=00", resp0, resp1); end
    total++; if (rd0 !== '0 || rd1 !== '0) begin bad++; $display("FAIL reset_rdata got=%h expected=0", rd0); end
    total++; if (ec0 !== 4'b0 || err0 !== 1'b0 || ec1 !== 4'b0 || err1 !== 1'b0)
      begin bad++; $display("FAIL reset_err got=%b/%b expected=0000/0", ec0, err0); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_preload_read();
    int lat; logic [255:0] rd;
    dut0.u_array.mem[5] = A5;
    transact(0, 0, 32'h0000_00A0, '0, lat, rd);
    chk_lat("preload_read", lat, 8);
    total++; if (rd !== A5) begin bad++; $display("FAIL preload_rdata got=%h expected=%h", rd, A5); end
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL preload_error got=%b expected=0", err0); end
    gap();
  endtask

  task automatic test_write_read();
    int lat; logic [255:0] rd;
    transact(0, 1, 32'h0000_0040, PAT, lat, rd);
    chk_lat("write_40", lat, 8);
    total++; if (rd !== A5) begin bad++; $display("FAIL rdata_held got=%h expected=%h", rd, A5); end
    gap();
    transact(0, 0, 32'h0000_0040, '0, lat, rd);
    chk_lat("read_40", lat, 8);
    total++; if (rd !== PAT) begin bad++; $display("FAIL read_40_data got=%h expected=%h", rd, PAT); end
    gap();
  endtask

  task automatic test_back_to_back();
    int lat; logic [255:0] rd;
    transact(0, 1, 32'h0000_0060, PAT2, lat, rd);
    chk_lat("b2b_write", lat, 8);
    // Reasserted during DONE: ignored for one edge, then accepted.
    transact(0, 0, 32'h0000_0060, '0, lat, rd);
    chk_lat("b2b_read", lat, 9);
    total++; if (rd !== PAT2) begin bad++; $display("FAIL b2b_rdata got=%h expected=%h", rd, PAT2); end
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL b2b_error got=%b expected=0", err0); end
    gap();
  endtask

  task automatic test_misaligned();
    int lat; logic [255:0] rd;
    transact(0, 0, 32'h0000_0044, '0, lat, rd);
    chk_lat("misaligned", lat, 8);
    total++; if (rd !== PAT) begin bad++; $display("FAIL misaligned_rdata got=%h expected=%h", rd, PAT); end
    total++; if (ec0 !== 4'b0010 || err0 !== 1'b1) begin bad++; $display("FAIL misaligned_cause got=%b/%b expected=0010/1", ec0, err0); end
    gap();
  endtask

  task automatic test_rw_both();
    int lat; logic [255:0] rd; bit seen;
    seen = 0;
    r0 = 1; w0 = 1; a0 = 32'h40; d0 = PATZ;
    for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (resp0 === 1'b1) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL rw_both_resp got=1 expected=0"); end
    total++; if (ec0 !== 4'b0011) begin bad++; $display("FAIL rw_both_cause got=%b expected=0011", ec0); end
    r0 = 0; w0 = 0;
    @(negedge clk);
    transact(0, 0, 32'h0000_00A0, '0, lat, rd);
    chk_lat("after_rw_both", lat, 8);
    total++; if (rd !== A5) begin bad++; $display("FAIL after_rw_both_rdata got=%h expected=%h", rd, A5); end
    gap();
  endtask

  task automatic test_drop();
    bit seen;
    seen = 0;
    r0 = 1; a0 = 32'h40;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 r0 = 0;
    for (int n = 0; n < 20; n++) begin @(posedge clk); #1; if (resp0 === 1'b1) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL drop_resp got=1 expected=0"); end
    total++; if (ec0 !== 4'b1011) begin bad++; $display("FAIL drop_cause got=%b expected=1011", ec0); end
    @(negedge clk);
  endtask

  task automatic test_rst_abort();
    int lat; logic [255:0] rd;
    w0 = 1; a0 = 32'hA0; d0 = PATZ;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (resp0 !== 1'b0 || rd0 !== '0 || ec0 !== 4'b0 || err0 !== 1'b0)
      begin bad++; $display("FAIL rst_async got resp=%b ec=%b err=%b expected all zero", resp0, ec0, err0); end
    w0 = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    transact(0, 0, 32'h0000_00A0, '0, lat, rd);
    chk_lat("rst_abort_read", lat, 8);
    total++; if (rd !== A5) begin bad++; $display("FAIL rst_abort_line got=%h expected=%h", rd, A5); end
    gap();
  endtask

  task automatic test_wdata_change();
    int lat; logic [255:0] rd; bit seen;
    seen = 0;
    w0 = 1; a0 = 32'h40; d0 = ~PAT;
    @(posedge clk);
    @(posedge clk);
    #1 d0 = PATZ;
    @(posedge clk);
    #1 w0 = 0;
    for (int n = 0; n < 15; n++) begin @(posedge clk); #1; if (resp0 === 1'b1) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL wdata_change_resp got=1 expected=0"); end
    total++; if (ec0 !== 4'b1000) begin bad++; $display("FAIL wdata_change_cause got=%b expected=1000", ec0); end
    transact(0, 0, 32'h0000_0040, '0, lat, rd);
    chk_lat("wdata_change_read", lat, 8);
    total++; if (rd !== PAT) begin bad++; $display("FAIL wdata_change_line got=%h expected=%h", rd, PAT); end
    gap();
  endtask

  task automatic test_fast_latency();
    int lat; logic [255:0] rd;
    dut1.u_array.mem[1] = {32{8'h11}};
    dut1.u_array.mem[2] = {32{8'h22}};
    dut1.u_array.mem[3] = {32{8'h33}};
    transact(1, 0, 32'h20, '0, lat, rd);
    chk_lat("fast_read1", lat, 1);
    total++; if (rd !== {32{8'h11}}) begin bad++; $display("FAIL fast_read1_data got=%h expected=11..", rd); end
    transact(1, 0, 32'h40, '0, lat, rd);
    chk_lat("fast_read2", lat, 2);
    total++; if (rd !== {32{8'h22}}) begin bad++; $display("FAIL fast_read2_data got=%h expected=22..", rd); end
    transact(1, 0, 32'h60, '0, lat, rd);
    chk_lat("fast_read3", lat, 2);
    total++; if (rd !== {32{8'h33}}) begin bad++; $display("FAIL fast_read3_data got=%h expected=33..", rd); end
    transact(1, 1, 32'h1E0, PAT, lat, rd);
    chk_lat("fast_write_last", lat, 4);
    transact(1, 1, 32'h100, PAT2, lat, rd);
    chk_lat("fast_write2", lat, 4);
    transact(1, 0, 32'h1E0, '0, lat, rd);
    chk_lat("fast_read_last", lat, 2);
    total++; if (rd !== PAT) begin bad++; $display("FAIL fast_last_line got=%h expected=%h", rd, PAT); end
    total++; if (ec1 !== 4'b0000) begin bad++; $display("FAIL fast_in_range_cause got=%b expected=0000", ec1); end
    transact(1, 0, 32'h200, '0, lat, rd);
    chk_lat("fast_oor_read", lat, 2);
    total++; if (rd !== '0) begin bad++; $display("FAIL fast_oor_rdata got=%h expected=0", rd); end
    total++; if (ec1 !== 4'b0100 || err1 !== 1'b1) begin bad++; $display("FAIL fast_oor_cause got=%b/%b expected=0100/1", ec1, err1); end
    gap();
    transact(1, 1, 32'h220, PATZ, lat, rd);
    chk_lat("fast_oor_write", lat, 3);
    gap();
    transact(1, 0, 32'h100, '0, lat, rd);
    chk_lat("fast_read_100", lat, 1);
    total++; if (rd !== PAT2) begin bad++; $display("FAIL fast_read_100_data got=%h expected=%h", rd, PAT2); end
    gap();
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_write_read();
    test_back_to_back();
    test_misaligned();
    test_rw_both();
    test_drop();
    test_rst_abort();
    test_wdata_change();
    test_fast_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
